// File: rtl/grid_scan_reader_if.sv
// Pixel-side bus of grid_scan_reader: counts, syncs and live grids in,
// per-pixel cell attributes and delayed syncs out.
interface grid_scan_reader_if;
  logic [10:0]           hcount_in;
  logic [9:0]            vcount_in;
  logic                  hsync_in;
  logic                  vsync_in;
  logic                  blank_in;
  logic [7:0][12:0][3:0] object_grid_in;
  logic [5:0][3:0]       time_grid_in;
  logic                  in_grid_out;
  logic [3:0]            object_out;
  logic [4:0]            tile_x_out;
  logic [4:0]            tile_y_out;
  logic                  bar_out;
  logic                  hsync_out;
  logic                  vsync_out;
  logic                  blank_out;

  modport master (
    output hcount_in, vcount_in, hsync_in, vsync_in, blank_in,
           object_grid_in, time_grid_in,
    input  in_grid_out, object_out, tile_x_out, tile_y_out, bar_out,
           hsync_out, vsync_out, blank_out
  );

  modport slave (
    input  hcount_in, vcount_in, hsync_in, vsync_in, blank_in,
           object_grid_in, time_grid_in,
    output in_grid_out, object_out, tile_x_out, tile_y_out, bar_out,
           hsync_out, vsync_out, blank_out
  );
endinterface

// File: rtl/grid_scan_reader.sv
// Maps each pixel to a cell of a frame-coherent grid snapshot through a
// fixed 3-stage pipeline; syncs are delayed to stay aligned.
module grid_scan_reader #(
  parameter logic [10:0] GRID_X0     = 11'd304,
  parameter logic [9:0]  GRID_Y0     = 10'd256,
  parameter logic [17:0] STATION_ROW = {6{3'd7}},
  parameter logic [23:0] STATION_COL = {4'd11, 4'd9, 4'd7, 4'd5, 4'd3, 4'd1}
) (
  input logic clk,
  input logic reset_n,
  grid_scan_reader_if.slave bus
);

  logic                  vs_prev_q;
  logic [7:0][12:0][3:0] snap_obj_q;
  logic [5:0][3:0]       snap_time_q;

  logic [11:0] hx_d;
  logic [10:0] vy_d;
  logic        inside_d;

  logic       inside1_q, hs1_q, vs1_q, bl1_q;
  logic [3:0] col1_q;
  logic [2:0] row1_q;
  logic [4:0] tx1_q, ty1_q;

  logic [3:0] code_d, t_d;
  logic       inside2_q, hs2_q, vs2_q, bl2_q;
  logic [3:0] code2_q, t2_q;
  logic [4:0] tx2_q, ty2_q;

  logic       bar_d;
  logic       in3_q, bar3_q, hs3_q, vs3_q, bl3_q;
  logic [3:0] obj3_q;
  logic [4:0] tx3_q, ty3_q;

  // Counts left of / above the grid wrap to huge values, so a single
  // unsigned range test on the offsets covers both sides of each axis.
  assign hx_d     = {1'b0, bus.hcount_in} - {1'b0, GRID_X0};
  assign vy_d     = {1'b0, bus.vcount_in} - {1'b0, GRID_Y0};
  assign inside_d = (hx_d < 12'd416) && (vy_d < 11'd256);

  always_comb begin
    code_d = '0;
    if (inside1_q && (col1_q < 4'd13))
      code_d = snap_obj_q[row1_q][col1_q];
    t_d = '0;
    // Descending scan lets the lowest-index station win a shared cell.
    for (int i = 5; i >= 0; i--) begin
      if (inside1_q && (row1_q == STATION_ROW[i*3 +: 3]) &&
          (col1_q == STATION_COL[i*4 +: 4]))
        t_d = snap_time_q[i];
    end
  end

  assign bar_d = inside2_q && (t2_q != 4'd0) && (ty2_q >= 5'd28) &&
                 ({1'b0, tx2_q} < {1'b0, t2_q, 1'b0});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev_q   <= 1'b1;
      snap_obj_q  <= '0;
      snap_time_q <= '0;
    end else begin
      vs_prev_q <= bus.vsync_in;
      if (vs_prev_q && !bus.vsync_in) begin
        snap_obj_q  <= bus.object_grid_in;
        snap_time_q <= bus.time_grid_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inside1_q <= 1'b0;
      col1_q    <= '0;
      row1_q    <= '0;
      tx1_q     <= '0;
      ty1_q     <= '0;
      hs1_q     <= 1'b1;
      vs1_q     <= 1'b1;
      bl1_q     <= 1'b0;
      inside2_q <= 1'b0;
      code2_q   <= '0;
      t2_q      <= '0;
      tx2_q     <= '0;
      ty2_q     <= '0;
      hs2_q     <= 1'b1;
      vs2_q     <= 1'b1;
      bl2_q     <= 1'b0;
      in3_q     <= 1'b0;
      obj3_q    <= '0;
      tx3_q     <= '0;
      ty3_q     <= '0;
      bar3_q    <= 1'b0;
      hs3_q     <= 1'b1;
      vs3_q     <= 1'b1;
      bl3_q     <= 1'b0;
    end else begin
      inside1_q <= inside_d;
      col1_q    <= hx_d[8:5];
      row1_q    <= vy_d[7:5];
      tx1_q     <= hx_d[4:0];
      ty1_q     <= vy_d[4:0];
      hs1_q     <= bus.hsync_in;
      vs1_q     <= bus.vsync_in;
      bl1_q     <= bus.blank_in;

      inside2_q <= inside1_q;
      code2_q   <= code_d;
      t2_q      <= t_d;
      tx2_q     <= tx1_q;
      ty2_q     <= ty1_q;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      bl2_q     <= bl1_q;

      in3_q     <= inside2_q;
      obj3_q    <= inside2_q ? code2_q : 4'd0;
      tx3_q     <= inside2_q ? tx2_q : 5'd0;
      ty3_q     <= inside2_q ? ty2_q : 5'd0;
      bar3_q    <= bar_d;
      hs3_q     <= hs2_q;
      vs3_q     <= vs2_q;
      bl3_q     <= bl2_q;
    end
  end

  assign bus.in_grid_out = in3_q;
  assign bus.object_out  = obj3_q;
  assign bus.tile_x_out  = tx3_q;
  assign bus.tile_y_out  = ty3_q;
  assign bus.bar_out     = bar3_q;
  assign bus.hsync_out   = hs3_q;
  assign bus.vsync_out   = vs3_q;
  assign bus.blank_out   = bl3_q;

endmodule

// File: tb/tb_grid_scan_reader.sv
// Scoreboard bench for grid_scan_reader: the driver queues hand-computed
// expectations, a monitor compares them when they leave the pipeline.
module tb_grid_scan_reader;

  typedef struct packed {
    logic       in_g;
    logic [3:0] obj;
    logic [4:0] tx;
    logic [4:0] ty;
    logic       bar;
    logic       hs;
    logic       vs;
    logic       bl;
  } out_t;

  localparam out_t RST_OUT = '{in_g: 1'b0, obj: 4'd0, tx: 5'd0, ty: 5'd0,
                               bar: 1'b0, hs: 1'b1, vs: 1'b1, bl: 1'b0};

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   cyc;

  out_t  exp_q[$];
  int    due_q[$];
  string name_q[$];

  grid_scan_reader_if bus ();

  grid_scan_reader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t sample();
    out_t o;
    o.in_g = bus.in_grid_out;
    o.obj  = bus.object_out;
    o.tx   = bus.tile_x_out;
    o.ty   = bus.tile_y_out;
    o.bar  = bus.bar_out;
    o.hs   = bus.hsync_out;
    o.vs   = bus.vsync_out;
    o.bl   = bus.blank_out;
    return o;
  endfunction

  task automatic check(input string nm, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (in,obj,tx,ty,bar,hs,vs,bl)", nm, act, exp);
    end
  endtask

  // Monitor: the pipeline presents one result per clock after a fixed latency.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (due_q.size() > 0 && due_q[0] <= cyc) begin
        if (due_q[0] < cyc) begin
          checks++;
          failures++;
          $display("FAIL %s missed_slot due=%0d now=%0d", name_q[0], due_q[0], cyc);
        end else begin
          check(name_q[0], sample(), exp_q[0]);
        end
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        void'(name_q.pop_front());
      end
    end
  end

  task automatic drv(input logic [10:0] h, input logic [9:0] v,
                     input logic hs, input logic vs, input logic bl,
                     input logic ein, input logic [3:0] eobj,
                     input logic [4:0] etx, input logic [4:0] ety,
                     input logic ebar, input string nm);
    out_t e;
    @(negedge clk);
    bus.hcount_in = h;
    bus.vcount_in = v;
    bus.hsync_in  = hs;
    bus.vsync_in  = vs;
    bus.blank_in  = bl;
    e = '{in_g: ein, obj: eobj, tx: etx, ty: ety, bar: ebar, hs: hs, vs: vs, bl: bl};
    exp_q.push_back(e);
    due_q.push_back(cyc + 3);
    name_q.push_back(nm);
  endtask

  task automatic px(input logic [10:0] h, input logic [9:0] v,
                    input logic ein, input logic [3:0] eobj,
                    input logic [4:0] etx, input logic [4:0] ety,
                    input logic ebar, input string nm);
    drv(h, v, 1'b1, 1'b1, 1'b1, ein, eobj, etx, ety, ebar, nm);
  endtask

  task automatic vs_pulse(input string nm);
    drv(11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, nm);
    drv(11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, {nm, "_b"});
  endtask

  task automatic drain_check(input string nm);
    repeat (6) @(posedge clk);
    #2;
    checks++;
    if (due_q.size() != 0) begin
      failures++;
      $display("FAIL %s pending=%0d required=0", nm, due_q.size());
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      bus.hcount_in      = 11'($urandom);
      bus.vcount_in      = 10'($urandom);
      bus.hsync_in       = 1'($urandom);
      bus.vsync_in       = 1'($urandom);
      bus.blank_in       = 1'($urandom);
      bus.object_grid_in = {13{$urandom}};
      bus.time_grid_in   = 24'($urandom);
    end
    @(posedge clk);
    #1;
    check("reset_hold", sample(), RST_OUT);

    @(negedge clk);
    bus.object_grid_in = '0;
    bus.time_grid_in   = '0;
    bus.hcount_in      = 11'd0;
    bus.vcount_in      = 10'd0;
    bus.hsync_in       = 1'b1;
    bus.vsync_in       = 1'b1;
    bus.blank_in       = 1'b1;
    reset_n            = 1'b1;

    px(11'd304, 10'd256, 1'b1, 4'd0, 5'd0, 5'd0, 1'b0, "origin");

    // Snapshot coherency on cell row 7 col 2
    bus.object_grid_in[7][2]  = 4'd5;
    bus.object_grid_in[0][12] = 4'd9;
    vs_pulse("vs1");
    px(11'd375, 10'd489, 1'b1, 4'd5, 5'd7, 5'd9, 1'b0, "snap_first");
    bus.object_grid_in[7][2] = 4'd3;
    px(11'd375, 10'd489, 1'b1, 4'd5, 5'd7, 5'd9, 1'b0, "snap_held");
    vs_pulse("vs2");
    px(11'd375, 10'd489, 1'b1, 4'd3, 5'd7, 5'd9, 1'b0, "snap_update");

    // Grid edges
    px(11'd719, 10'd256, 1'b1, 4'd9, 5'd31, 5'd0, 1'b0, "x_last");
    px(11'd720, 10'd256, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "x_past");
    px(11'd303, 10'd256, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "x_before");
    px(11'd304, 10'd511, 1'b1, 4'd0, 5'd0, 5'd31, 1'b0, "y_last");
    px(11'd304, 10'd512, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "y_past");
    px(11'd304, 10'd255, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "y_before");

    // Progress bar on station 1 (row 7, col 3)
    bus.time_grid_in[1] = 4'd6;
    vs_pulse("vs3");
    px(11'd411, 10'd508, 1'b1, 4'd0, 5'd11, 5'd28, 1'b1, "bar_t6_tx11");
    px(11'd412, 10'd508, 1'b1, 4'd0, 5'd12, 5'd28, 1'b0, "bar_t6_tx12");
    px(11'd400, 10'd507, 1'b1, 4'd0, 5'd0, 5'd27, 1'b0, "bar_ty27");
    px(11'd336, 10'd510, 1'b1, 4'd0, 5'd0, 5'd30, 1'b0, "bar_station0_t0");
    bus.time_grid_in[1] = 4'd15;
    vs_pulse("vs4");
    px(11'd429, 10'd508, 1'b1, 4'd0, 5'd29, 5'd28, 1'b1, "bar_t15_tx29");
    px(11'd430, 10'd508, 1'b1, 4'd0, 5'd30, 5'd28, 1'b0, "bar_t15_tx30");

    // Sync/blank alignment
    drv(11'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "sync0");
    drv(11'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "sync1");
    drv(11'd0, 10'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "sync2");
    drv(11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "sync3");
    drv(11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "sync4");
    drv(11'd0, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "sync5");
    drv(11'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "sync6");
    drv(11'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 5'd0, 5'd0, 1'b0, "sync7");

    px(11'd375, 10'd489, 1'b1, 4'd3, 5'd7, 5'd9, 1'b0, "pre_reset");
    drain_check("drain_pre_reset");

    // Asynchronous mid-frame reset, then the grid must read empty
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("reset_async", sample(), RST_OUT);
    @(negedge clk);
    reset_n = 1'b1;
    px(11'd375, 10'd489, 1'b1, 4'd0, 5'd7, 5'd9, 1'b0, "post_reset_empty");
    drain_check("drain_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grid_scan_reader.md
# grid_scan_reader

Pixel-domain reader for the game-state grids that the action block writes once per frame. It takes a frame-coherent snapshot of `object_grid` and `time_grid` at the start of each vertical sync pulse. Each incoming (hcount, vcount) is mapped to a grid cell through a 3-stage pipeline. The outputs are the cell's object code, intra-tile coordinates and a chop-progress-bar flag, with all syncs delayed to match; the sprite/colour renderer downstream consumes them.

## Interface

- `GRID_X0`, default 11'd304: left pixel of grid column 0.
- `GRID_Y0`, default 10'd256: top pixel of grid row 0.
- `STATION_ROW`, default {6{3'd7}}: packed 6×3 bits; grid row of chopping station i (`time_grid` index i).
- `STATION_COL`, default {4'd11,4'd9,4'd7,4'd5,4'd3,4'd1}: packed 6×4 bits; grid column of station i (index 0 at LSBs).

Ports:

- `clk` in 1: pixel clock; the only clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `hcount_in` in 11: current pixel x.
- `vcount_in` in 10: current pixel y.
- `hsync_in`, `vsync_in`, `blank_in` in 1 each: active-low syncs and blank, aligned with the counts.
- `object_grid_in` in [7:0][12:0][3:0]: live object codes from action; indexed [row][col]; 0 = empty.
- `time_grid_in` in [5:0][3:0]: live chop timers, 0..15.
- `in_grid_out` out 1: pixel lies inside the 13×8 grid.
- `object_out` out 4: snapshot object code of the cell.
- `tile_x_out` out 5: x offset within the 32-px tile.
- `tile_y_out` out 5: y offset within the 32-px tile.
- `bar_out` out 1: pixel belongs to a progress bar.
- `hsync_out`, `vsync_out`, `blank_out` out 1 each: inputs delayed 3 cycles.

## Operation

- **Snapshot.**
  - A register `vs_prev` holds the previous `vsync_in`.
  - On a clock edge where `vs_prev`=1 and `vsync_in`=0, both grids are copied into internal snapshot registers.
  - The snapshot is otherwise held. Mid-frame changes on `*_grid_in` are never visible.
  - Reset clears the snapshot to all 0 and sets `vs_prev`=1.
- **Stage 1.** Register the following:
  - hx = hcount−GRID_X0 and vy = vcount−GRID_Y0, each unsigned and 1 bit wider than its count.
  - inside = (hcount ≥ GRID_X0) && (hcount < GRID_X0+416) && (vcount ≥ GRID_Y0) && (vcount < GRID_Y0+256).
  - col = hx[8:5] (0..12), row = vy[7:5] (0..7), tx = hx[4:0], ty = vy[4:0].
  - The syncs and blank.
- **Stage 2.**
  - Register code = snapshot_obj[row][col].
  - For each station i, compute hit_i = inside && row==STATION_ROW[i] && col==STATION_COL[i].
  - Register t = time of the lowest-index hit, or 0 if none.
  - Pass tx, ty, inside and the syncs through.
- **Stage 3.** Register the outputs:
  - in_grid_out = inside.
  - object_out = inside ? code : 0.
  - tile_x_out / tile_y_out = inside ? tx/ty : 0.
  - bar_out = inside && t≠0 && ty ≥ 28 && tx < 2·t, with 2·t computed at 6 bits so that t=15 gives 30.
- `blank_in`=0 does not gate the computation; the downstream block masks with `blank_out`.

## Timing

- Latency is exactly 3 clocks for every output. A new pixel is accepted every clock and nothing stalls.
- A snapshot taken on edge N is used by every pixel that reaches stage 2 at edge N+1 or later.
- The sync falling edge falls inside vertical blanking, so the whole visible frame uses a single snapshot.
- Reset values:
  - `in_grid_out`, `object_out`, `tile_x_out`, `tile_y_out`, `bar_out`, `blank_out` = 0.
  - `hsync_out`, `vsync_out` = 1.
  - All pipeline registers take the same inactive values.
- Reset asserted mid-frame forces the outputs immediately, asynchronously. After release the outputs are valid 3 clocks later, and the grid reads as empty until the next vsync falling edge.
- Boundaries:
  - hcount = GRID_X0+415 is inside with col=12, tx=31.
  - hcount = GRID_X0+416 is outside.
  - hcount < GRID_X0 is outside; the underflow wraps in the subtraction and is masked by `inside`.
  - Two stations mapped to the same cell resolve to the lower index.

## Test plan

- **Reset.** Hold `reset_n`=0 with random inputs → outputs equal the reset values. Release and drive hcount=GRID_X0, vcount=GRID_Y0 → 3 clocks later `in_grid_out`=1, `object_out`=0, tile 0/0.
- **Snapshot coherency.** Set object_grid[7][2]=4'd5, then pulse vsync low. Sample pixel x=GRID_X0+64+7, y=GRID_Y0+224+9 → `object_out`=5, `tile_x_out`=7, `tile_y_out`=9. Change the cell to 3 without a vsync → still 5. After the next vsync falling edge → 3.
- **Grid edges.** Sample x=GRID_X0+415 → col 12, tx 31, `in_grid_out`=1. Sample x=GRID_X0+416 → all outputs 0. Sample x=GRID_X0−1 → 0. Repeat in y with vy=255 and vy=256.
- **Progress bar.** Set time_grid[1]=4'd6 and snapshot. In station cell (7,3) at ty=28: tx=11 → `bar_out`=1; tx=12 → 0. At ty=27 → 0. Set t=15: tx=29 → 1, tx=30 → 0.
- **Pipeline alignment.** Drive a hsync/vsync/blank pattern with unique transitions → the outputs reproduce it exactly 3 clocks later, cycle for cycle.
